// File: rtl/port_pkg.sv
// ============================================================================
// port_pkg : shared widths and word type for processor I/O port buffers
// Rev 1.0
// ============================================================================
`default_nettype none

package port_pkg;

   localparam int PORT_WIDTH     = 16;
   localparam int OUT_FIFO_DEPTH = 4;

   typedef logic [PORT_WIDTH-1:0] port_word_t;

endpackage

`default_nettype wire

// File: rtl/port_fifo_mem.sv
// ============================================================================
// port_fifo_mem : DEPTH x DATA_WIDTH array, synchronous write, async read
// Rev 1.0
// ============================================================================
`default_nettype none

module port_fifo_mem
   import port_pkg::*;
#(
   parameter int DATA_WIDTH = PORT_WIDTH,
   parameter int DEPTH      = OUT_FIFO_DEPTH,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Contents are deliberately unreset; occupancy logic masks stale entries.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/out_port_buffer.sv
// ============================================================================
// out_port_buffer : show-ahead FIFO between Controller OUT path and device pins
// Rev 1.0
// ============================================================================
`default_nettype none

module out_port_buffer
   import port_pkg::*;
#(
   parameter int DATA_WIDTH = PORT_WIDTH,
   parameter int DEPTH      = OUT_FIFO_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DATA_WIDTH-1:0]      outPortData,
   input  logic                       outSignalEn,
   output logic [DATA_WIDTH-1:0]      devData,
   output logic                       devValid,
   input  logic                       devReady,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]         wp;
   logic [AW-1:0]         rp;
   logic [CW-1:0]         occ;
   logic                  ovf;
   logic                  pop;
   logic                  push;
   logic                  drop;
   logic [DATA_WIDTH-1:0] head;

   assign devValid = (occ != '0);
   assign full     = (occ == CW'(DEPTH));
   assign count    = occ;
   assign overflow = ovf;

   assign pop  = devValid && devReady;
   // A full FIFO still accepts a push when the head is leaving this cycle.
   assign push = outSignalEn && (!full || pop);
   assign drop = outSignalEn && full && !pop;

   port_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push && !reset),
      .waddr (wp),
      .wdata (outPortData),
      .raddr (rp),
      .rdata (head)
   );

   assign devData = devValid ? head : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         wp  <= '0;
         rp  <= '0;
         occ <= '0;
         ovf <= 1'b0;
      end else begin
         if (push) begin
            wp <= wp + 1'b1;
         end
         if (pop) begin
            rp <= rp + 1'b1;
         end
         if (push && !pop) begin
            occ <= occ + 1'b1;
         end else if (pop && !push) begin
            occ <= occ - 1'b1;
         end
         if (drop) begin
            ovf <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_out_port_buffer.sv
// ============================================================================
// tb_out_port_buffer : directed self-checking bench for out_port_buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_out_port_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] outPortData;
   logic        outSignalEn;
   logic [15:0] devData;
   logic        devValid;
   logic        devReady;
   logic [2:0]  count;
   logic        full;
   logic        overflow;

   int errors = 0;
   int checks = 0;

   out_port_buffer #(
      .DATA_WIDTH (16),
      .DEPTH      (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .outPortData (outPortData),
      .outSignalEn (outSignalEn),
      .devData     (devData),
      .devValid    (devValid),
      .devReady    (devReady),
      .count       (count),
      .full        (full),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle before driving or sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [15:0] d);
      outPortData = d;
      outSignalEn = 1'b1;
      step();
      outSignalEn = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"},    32'(devValid), 0);
      check({tag, "_data"},     32'(devData),  0);
      check({tag, "_count"},    32'(count),    0);
      check({tag, "_full"},     32'(full),     0);
      check({tag, "_overflow"}, 32'(overflow), 0);
   endtask

   task automatic drain_expect(input string tag, input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2, input logic [15:0] w3);
      logic [15:0] exp_words [4];
      exp_words = '{w0, w1, w2, w3};
      devReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check({tag, "_drain_valid"}, 32'(devValid), 1);
         check({tag, "_drain_data"},  32'(devData),  32'(exp_words[i]));
         step();
      end
      devReady = 1'b0;
      check({tag, "_drain_empty"}, 32'(devValid), 0);
      check({tag, "_drain_count"}, 32'(count),    0);
   endtask

   initial begin
      reset       = 1'b0;
      outPortData = '0;
      outSignalEn = 1'b0;
      devReady    = 1'b0;
      #2;

      // Reset then idle
      do_reset();
      check_idle("rst");

      // Single word, show-ahead before devReady
      push_word(16'd10);
      check("single_valid", 32'(devValid), 1);
      check("single_data",  32'(devData),  10);
      check("single_count", 32'(count),    1);
      step();
      check("single_hold",  32'(devData),  10);
      devReady = 1'b1;
      step();
      devReady = 1'b0;
      check("single_popped_valid", 32'(devValid), 0);
      check("single_popped_count", 32'(count),    0);

      // Fill and overflow
      for (int i = 1; i <= 5; i++) begin
         push_word(16'(i));
      end
      check("fill_full",     32'(full),     1);
      check("fill_count",    32'(count),    4);
      check("fill_overflow", 32'(overflow), 1);
      drain_expect("fill", 16'd1, 16'd2, 16'd3, 16'd4);
      check("fill_ovf_sticky", 32'(overflow), 1);
      do_reset();
      check_idle("rst2");

      // Full with simultaneous push and pop
      for (int i = 1; i <= 4; i++) begin
         push_word(16'(i));
      end
      check("fullpp_pre_full", 32'(full), 1);
      outPortData = 16'd9;
      outSignalEn = 1'b1;
      devReady    = 1'b1;
      step();
      outSignalEn = 1'b0;
      devReady    = 1'b0;
      check("fullpp_overflow", 32'(overflow), 0);
      check("fullpp_count",    32'(count),    4);
      check("fullpp_head",     32'(devData),  2);
      drain_expect("fullpp", 16'd2, 16'd3, 16'd4, 16'd9);

      // Streaming through pointer wrap
      devReady = 1'b1;
      for (int i = 0; i < 12; i++) begin
         outPortData = 16'(i);
         outSignalEn = 1'b1;
         step();
         check("stream_valid", 32'(devValid), 1);
         check("stream_data",  32'(devData),  32'(i));
         check("stream_count", 32'(count),    1);
      end
      outSignalEn = 1'b0;
      step();
      devReady = 1'b0;
      check("stream_end_valid", 32'(devValid), 0);
      check("stream_end_count", 32'(count),    0);
      check("stream_overflow",  32'(overflow), 0);

      // Reset mid-operation with push and pop requested
      for (int i = 0; i < 3; i++) begin
         push_word(16'(20 + i));
      end
      check("midrst_pre_count", 32'(count), 3);
      reset       = 1'b1;
      outSignalEn = 1'b1;
      devReady    = 1'b1;
      outPortData = 16'd77;
      step();
      reset       = 1'b0;
      outSignalEn = 1'b0;
      devReady    = 1'b0;
      check_idle("midrst");
      step();
      check("midrst_still_empty", 32'(devValid), 0);

      // Post-reset push lands at slot zero and comes out correctly
      push_word(16'd55);
      check("post_rst_data",  32'(devData), 55);
      check("post_rst_count", 32'(count),   1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
